// File: rtl/secret_checker_pkg.sv
// Shared types and constants for the secret_checker run-based comparator.
// Holds the checker FSM state encoding and the "no error seen" marker.
// Also a saturating increment used by the mismatch counter.
package secret_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Marker for first_err_idx when a run has seen no mismatch yet.
  localparam logic [15:0] NO_ERR = 16'hFFFF;

  // Count up, but stick at all-ones so long runs never wrap back to zero.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/secret_model.sv
// Golden model of the checked accumulator: exp += accum_in + SECRET each cycle.
// Latency: exp updates one cycle after accum_in; exp_byp is combinational.
// No backpressure: the model free-runs every cycle regardless of checker state.
module secret_model
  import secret_checker_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int SECRET = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] accum_in_i,
  input  logic             accum_bypass_i,
  output logic [WIDTH-1:0] exp_o,
  output logic [WIDTH-1:0] exp_byp_o
);

  localparam logic [WIDTH-1:0] SECRET_W = WIDTH'(SECRET);

  logic [WIDTH-1:0] exp_q;
  logic [WIDTH-1:0] exp_d;

  // Next accumulator value; the sum wraps naturally at WIDTH bits.
  always_comb begin
    exp_d = exp_q + accum_in_i + SECRET_W;
  end

  // Accumulator register, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) exp_q <= '0;
    else       exp_q <= exp_d;
  end

  assign exp_o     = exp_q;
  assign exp_byp_o = accum_bypass_i ? accum_in_i : exp_q;

endmodule

// File: rtl/secret_checker.sv
// Compares a checked accumulator against secret_model for NUM_CHECKS cycles per run.
// Latency: checks on the NUM_CHECKS edges after start; done one edge after the last check.
// No backpressure: start is ignored while a run is in progress.
module secret_checker
  import secret_checker_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int SECRET     = 7,
  parameter int NUM_CHECKS = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] accum_in,
  input  logic             accum_bypass,
  input  logic [WIDTH-1:0] accum_out,
  input  logic [WIDTH-1:0] accum_bypass_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      err_count,
  output logic [15:0]      first_err_idx
);

  // Index value reached after the last check; RUN spends one extra cycle here.
  localparam logic [15:0] END_IDX = 16'(NUM_CHECKS);

  state_e      state_q, state_d;
  logic [15:0] idx_q, idx_d;
  logic [15:0] err_q, err_d;
  logic [15:0] first_q, first_d;

  logic [WIDTH-1:0] exp_w;
  logic [WIDTH-1:0] exp_byp_w;
  logic             mismatch;

  secret_model #(
    .WIDTH  (WIDTH),
    .SECRET (SECRET)
  ) u_model (
    .clk            (clk),
    .reset          (reset),
    .accum_in_i     (accum_in),
    .accum_bypass_i (accum_bypass),
    .exp_o          (exp_w),
    .exp_byp_o      (exp_byp_w)
  );

  // Either output disagreeing counts as a single mismatch for this check.
  assign mismatch = (accum_out != exp_w) || (accum_bypass_out != exp_byp_w);

  // State and run-statistics registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      err_q   <= '0;
      first_q <= NO_ERR;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      first_q <= first_d;
    end
  end

  // Next-state logic: launch a run, perform one check per RUN cycle, then settle in DONE.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    err_d   = err_q;
    first_d = first_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_RUN;
          idx_d   = '0;
          err_d   = '0;
          first_d = NO_ERR;
        end
      end
      ST_RUN: begin
        if (idx_q == END_IDX) begin
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + 16'd1;
          if (mismatch) begin
            err_d = sat_inc(err_q);
            // err_q is zero only before the first mismatch of this run.
            if (err_q == 16'd0) first_d = idx_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy          = (state_q == ST_RUN);
  assign done          = (state_q == ST_DONE);
  assign pass          = done && (err_q == 16'd0);
  assign err_count     = err_q;
  assign first_err_idx = first_q;

endmodule
